// File: rtl/commit_trace_buffer.sv
// Retire-trace recorder: classifies each accepted commit, buffers it in a show-ahead
// circular FIFO drained over valid/ready, and tracks instruction/cycle/drop counters.
module commit_trace_buffer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int REG_W       = 4,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid,
    input  logic [ADDR_W-1:0] commit_pc,
    input  logic              reg_write,
    input  logic [REG_W-1:0]  write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              halt,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [2:0]        trace_kind,
    output logic [CNT_W-1:0]  trace_inum,
    output logic [ADDR_W-1:0] trace_pc,
    output logic [REG_W-1:0]  trace_reg,
    output logic [DATA_W-1:0] trace_value,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic              halted,
    output logic              timeout,
    output logic              done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [2:0] KIND_LOAD  = 3'd0;
    localparam logic [2:0] KIND_ALU   = 3'd1;
    localparam logic [2:0] KIND_STORE = 3'd2;
    localparam logic [2:0] KIND_NOP   = 3'd3;
    localparam logic [2:0] KIND_HALT  = 3'd4;

    typedef enum logic [1:0] {RUN, HALTED, TIMEOUT} stateT;

    typedef struct packed {
        logic [2:0]        kind;
        logic [CNT_W-1:0]  inum;
        logic [ADDR_W-1:0] pc;
        logic [REG_W-1:0]  regIdx;
        logic [DATA_W-1:0] value;
        logic [ADDR_W-1:0] addr;
    } entryT;

    stateT            state;
    entryT            fifoMem [DEPTH];
    entryT            newEntry;
    entryT            headEntry;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             fifoEmpty;
    logic             fifoFull;
    logic             accept;
    logic             popNow;
    logic             pushNow;
    logic             dropNow;

    // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[IDX_W-1:0] == rdPtr[IDX_W-1:0]) &&
                       (wrPtr[PTR_W-1] != rdPtr[PTR_W-1]);
    assign accept    = commit_valid && (state == RUN);
    assign popNow    = !fifoEmpty && trace_ready;
    assign pushNow   = accept && (!fifoFull || popNow);
    assign dropNow   = accept && fifoFull && !popNow;

    // Classification priority: halt, then register write, then store, else no-writeback.
    always_comb begin
        newEntry      = '0;
        newEntry.inum = inst_count;
        newEntry.pc   = commit_pc;
        if (halt) begin
            newEntry.kind = KIND_HALT;
        end else if (reg_write) begin
            newEntry.kind   = mem_read ? KIND_LOAD : KIND_ALU;
            newEntry.regIdx = write_reg;
            newEntry.value  = write_data;
            newEntry.addr   = mem_read ? mem_addr : '0;
        end else if (mem_write) begin
            newEntry.kind  = KIND_STORE;
            newEntry.value = mem_data;
            newEntry.addr  = mem_addr;
        end else begin
            newEntry.kind = KIND_NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (pushNow) begin
            fifoMem[wrPtr[IDX_W-1:0]] <= newEntry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wrPtr       <= '0;
            rdPtr       <= '0;
            inst_count  <= '0;
            cycle_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (pushNow) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popNow) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (accept && (inst_count != '1)) begin
                inst_count <= inst_count + CNT_W'(1);
            end
            if (dropNow) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + CNT_W'(1);
                end
            end
            // A halt on the limit cycle takes precedence over the watchdog.
            if (state == RUN) begin
                cycle_count <= cycle_count + CNT_W'(1);
                if (accept && halt) begin
                    state <= HALTED;
                end else if (cycle_count == CNT_W'(CYCLE_LIMIT - 1)) begin
                    state <= TIMEOUT;
                end
            end
        end
    end

    assign headEntry   = fifoEmpty ? '0 : fifoMem[rdPtr[IDX_W-1:0]];
    assign trace_valid = !fifoEmpty;
    assign trace_kind  = headEntry.kind;
    assign trace_inum  = headEntry.inum;
    assign trace_pc    = headEntry.pc;
    assign trace_reg   = headEntry.regIdx;
    assign trace_value = headEntry.value;
    assign trace_addr  = headEntry.addr;
    assign halted      = (state == HALTED);
    assign timeout     = (state == TIMEOUT);
    assign done        = (halted || timeout) && fifoEmpty;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_commit_trace_buffer;

    localparam int DEPTH = 16;
    localparam int LIMIT = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit_valid = 1'b0;
    logic [15:0] commit_pc = '0;
    logic        reg_write = 1'b0;
    logic [3:0]  write_reg = '0;
    logic [15:0] write_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_data = '0;
    logic        halt = 1'b0;
    logic        trace_ready = 1'b0;
    logic        trace_valid;
    logic [2:0]  trace_kind;
    logic [31:0] trace_inum;
    logic [15:0] trace_pc;
    logic [3:0]  trace_reg;
    logic [15:0] trace_value;
    logic [15:0] trace_addr;
    logic [31:0] inst_count;
    logic [31:0] cycle_count;
    logic [31:0] drop_count;
    logic        overflow;
    logic        halted;
    logic        timeout;
    logic        done;

    commit_trace_buffer #(.DEPTH(DEPTH), .CYCLE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .halt(halt), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_kind(trace_kind), .trace_inum(trace_inum),
        .trace_pc(trace_pc), .trace_reg(trace_reg), .trace_value(trace_value),
        .trace_addr(trace_addr), .inst_count(inst_count), .cycle_count(cycle_count),
        .drop_count(drop_count), .overflow(overflow), .halted(halted),
        .timeout(timeout), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [3:0]  rg;
        logic [15:0] value;
        logic [15:0] addr;
    } mEntryT;

    int     errors = 0;
    int     checks = 0;
    bit     cmpEn = 1'b0;
    mEntryT modelQ[$];
    mEntryT drainLog[$];
    mEntryT mHead;
    mEntryT mNew;
    int unsigned mInst, mCycle, mDrop, mOcc;
    bit     mOverflow, mPop, mAcc;
    int     mState;  // 0 running, 1 halted, 2 timed out
    int     expKind[4]  = '{1, 0, 2, 3};
    int     expPc[4]    = '{'h0000, 'h0002, 'h0004, 'h0006};
    int     expReg[4]   = '{3, 1, 0, 0};
    int     expValue[4] = '{'h0005, 'h1234, 'hBEEF, 0};
    int     expAddr[4]  = '{0, 'h0040, 'h0042, 0};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Builds the trace record the specification's rules assign to the current commit inputs.
    function automatic mEntryT classify(input int unsigned inum);
        mEntryT e;
        e = '0;
        e.inum = inum;
        e.pc = commit_pc;
        if (halt) e.kind = 3'd4;
        else if (reg_write && mem_read) begin
            e.kind = 3'd0; e.rg = write_reg; e.value = write_data; e.addr = mem_addr;
        end else if (reg_write) begin
            e.kind = 3'd1; e.rg = write_reg; e.value = write_data;
        end else if (mem_write) begin
            e.kind = 3'd2; e.value = mem_data; e.addr = mem_addr;
        end else e.kind = 3'd3;
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            modelQ.delete();
            mInst = 0; mCycle = 0; mDrop = 0; mOverflow = 0; mState = 0;
        end else begin
            mOcc = modelQ.size();
            mPop = (mOcc != 0) && trace_ready;
            mAcc = commit_valid && (mState == 0);
            if (mPop) void'(modelQ.pop_front());
            if (mAcc) begin
                mNew = classify(mInst);
                if (mOcc < DEPTH || mPop) modelQ.push_back(mNew);
                else begin
                    mOverflow = 1;
                    if (mDrop != 32'hFFFF_FFFF) mDrop++;
                end
                if (mInst != 32'hFFFF_FFFF) mInst++;
            end
            if (mState == 0) begin
                if (mAcc && halt) mState = 1;
                else if (mCycle == LIMIT - 1) mState = 2;
                mCycle++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            mHead = (modelQ.size() != 0) ? modelQ[0] : '0;
            checkOutput("trace_valid", 64'(trace_valid), 64'(modelQ.size() != 0));
            checkOutput("trace_kind", 64'(trace_kind), 64'(mHead.kind));
            checkOutput("trace_inum", 64'(trace_inum), 64'(mHead.inum));
            checkOutput("trace_pc", 64'(trace_pc), 64'(mHead.pc));
            checkOutput("trace_reg", 64'(trace_reg), 64'(mHead.rg));
            checkOutput("trace_value", 64'(trace_value), 64'(mHead.value));
            checkOutput("trace_addr", 64'(trace_addr), 64'(mHead.addr));
            checkOutput("inst_count", 64'(inst_count), 64'(mInst));
            checkOutput("cycle_count", 64'(cycle_count), 64'(mCycle));
            checkOutput("drop_count", 64'(drop_count), 64'(mDrop));
            checkOutput("overflow", 64'(overflow), 64'(mOverflow));
            checkOutput("halted", 64'(halted), 64'(mState == 1));
            checkOutput("timeout", 64'(timeout), 64'(mState == 2));
            checkOutput("done", 64'(done), 64'((mState != 0) && (modelQ.size() == 0)));
        end
        if (!rst && trace_valid && trace_ready) begin
            drainLog.push_back('{trace_kind, trace_inum, trace_pc, trace_reg, trace_value, trace_addr});
        end
    end

    task automatic applyStimulus(input logic cv, input logic [15:0] pc, input logic rw,
                                 input logic [3:0] wr, input logic [15:0] wd, input logic mr,
                                 input logic mw, input logic [15:0] ma, input logic [15:0] md,
                                 input logic h);
        commit_valid = cv; commit_pc = pc; reg_write = rw; write_reg = wr; write_data = wd;
        mem_read = mr; mem_write = mw; mem_addr = ma; mem_data = md; halt = h;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic commitAlu(input logic [15:0] pc, input logic [3:0] r, input logic [15:0] v);
        applyStimulus(1, pc, 1, r, v, 0, 0, 16'h1111, 16'h2222, 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        drainLog.delete();
    endtask

    initial begin
        trace_ready = 1'b1;
        doReset();
        cmpEn = 1'b1;
        checkOutput("reset_valid", 64'(trace_valid), 0);
        checkOutput("reset_inst", 64'(inst_count), 0);
        checkOutput("reset_done", 64'(done), 0);

        // Four classified commits flowing straight through.
        commitAlu(16'h0000, 4'd3, 16'h0005);
        applyStimulus(1, 16'h0002, 1, 4'd1, 16'h1234, 1, 0, 16'h0040, 16'h7777, 0);
        applyStimulus(1, 16'h0004, 0, 4'd7, 16'h5555, 0, 1, 16'h0042, 16'hBEEF, 0);
        applyStimulus(1, 16'h0006, 0, 4'd2, 16'h3333, 0, 0, 16'h0099, 16'h4444, 0);
        idle(3);
        checkOutput("t1_inst", 64'(inst_count), 4);
        checkOutput("t1_drained", 64'(drainLog.size()), 4);
        if (drainLog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("t1_inum", 64'(drainLog[i].inum), 64'(i));
                checkOutput("t1_kind", 64'(drainLog[i].kind), 64'(expKind[i]));
                checkOutput("t1_pc", 64'(drainLog[i].pc), 64'(expPc[i]));
                checkOutput("t1_reg", 64'(drainLog[i].rg), 64'(expReg[i]));
                checkOutput("t1_value", 64'(drainLog[i].value), 64'(expValue[i]));
                checkOutput("t1_addr", 64'(drainLog[i].addr), 64'(expAddr[i]));
            end
        end

        // Bubbles are ignored.
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(i % 2 == 0, 16'(i), 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_cycle", 64'(cycle_count), 10);
        checkOutput("t2_inst", 64'(inst_count), 5);
        idle(3);
        checkOutput("t2_drained", 64'(drainLog.size()), 5);

        // Overflow: 20 commits into a 16-deep FIFO with no consumer.
        doReset();
        trace_ready = 1'b0;
        for (int i = 0; i < 20; i++) commitAlu(16'(i * 2), 4'(i), 16'(i));
        checkOutput("t3_drop", 64'(drop_count), 4);
        checkOutput("t3_overflow", 64'(overflow), 1);
        checkOutput("t3_inst", 64'(inst_count), 20);
        trace_ready = 1'b1;
        idle(18);
        checkOutput("t3_drained", 64'(drainLog.size()), 16);
        applyStimulus(1, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        checkOutput("t3_drained2", 64'(drainLog.size()), 17);
        if (drainLog.size() == 17) begin
            checkOutput("t3_first_inum", 64'(drainLog[0].inum), 0);
            checkOutput("t3_last_kept_inum", 64'(drainLog[15].inum), 15);
            checkOutput("t3_next_inum", 64'(drainLog[16].inum), 20);
        end

        // Full FIFO with simultaneous pop accepts the push.
        doReset();
        trace_ready = 1'b0;
        for (int i = 0; i < 16; i++) commitAlu(16'(i), 4'd2, 16'(i + 100));
        trace_ready = 1'b1;
        commitAlu(16'h0200, 4'd4, 16'h0044);
        checkOutput("t4_drop", 64'(drop_count), 0);
        checkOutput("t4_overflow", 64'(overflow), 0);
        checkOutput("t4_inst", 64'(inst_count), 17);
        idle(18);
        checkOutput("t4_drained", 64'(drainLog.size()), 17);
        if (drainLog.size() == 17) checkOutput("t4_last_inum", 64'(drainLog[16].inum), 16);

        // Halt as inum 7; later commits are ignored.
        doReset();
        for (int i = 0; i < 7; i++) commitAlu(16'(i * 2), 4'd1, 16'(i));
        applyStimulus(1, 16'h000A, 1, 4'd5, 16'h0099, 0, 0, 16'h0011, 0, 1);
        checkOutput("t5_halted", 64'(halted), 1);
        checkOutput("t5_done_early", 64'(done), 0);
        for (int i = 0; i < 3; i++) commitAlu(16'h0020, 4'd6, 16'h0066);
        idle(3);
        checkOutput("t5_inst", 64'(inst_count), 8);
        checkOutput("t5_done", 64'(done), 1);
        checkOutput("t5_drained", 64'(drainLog.size()), 8);
        if (drainLog.size() == 8) begin
            checkOutput("t5_kind", 64'(drainLog[7].kind), 4);
            checkOutput("t5_inum", 64'(drainLog[7].inum), 7);
            checkOutput("t5_pc", 64'(drainLog[7].pc), 16'h000A);
            checkOutput("t5_value", 64'(drainLog[7].value), 0);
        end

        // Watchdog; a commit on the limit cycle is still accepted.
        doReset();
        idle(49);
        checkOutput("t6_pre_timeout", 64'(timeout), 0);
        checkOutput("t6_pre_cycle", 64'(cycle_count), 49);
        applyStimulus(1, 16'h0030, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_timeout", 64'(timeout), 1);
        checkOutput("t6_cycle", 64'(cycle_count), 50);
        checkOutput("t6_inst", 64'(inst_count), 1);
        commitAlu(16'h0032, 4'd1, 16'h0001);
        idle(1);
        checkOutput("t6_inst_frozen", 64'(inst_count), 1);
        checkOutput("t6_cycle_frozen", 64'(cycle_count), 50);
        checkOutput("t6_done", 64'(done), 1);

        // Halt coinciding with the limit cycle wins.
        doReset();
        idle(49);
        applyStimulus(1, 16'h0040, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("t7_halted", 64'(halted), 1);
        checkOutput("t7_timeout", 64'(timeout), 0);
        checkOutput("t7_cycle", 64'(cycle_count), 50);

        // Reset in the middle of a drain.
        doReset();
        trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) commitAlu(16'(i + 1), 4'd3, 16'(i + 1));
        trace_ready = 1'b1;
        idle(1);
        rst = 1'b1;
        idle(1);
        checkOutput("t8_valid", 64'(trace_valid), 0);
        checkOutput("t8_pc", 64'(trace_pc), 0);
        checkOutput("t8_inst", 64'(inst_count), 0);
        checkOutput("t8_cycle", 64'(cycle_count), 0);
        checkOutput("t8_state", 64'({halted, timeout, done}), 0);
        rst = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
